// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, default tap masks and the LFSR step function
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        VALID = 2'd2
    } gen_state_e;

    typedef struct packed {
        logic [63:0] next;
        logic        bit_out;
    } step_t;

    // Maximal-length masks; bit k set means state[k] feeds the XOR.
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hD008;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;
    localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

    // Operates on a 64-bit container; bits at or above width are forced to zero.
    function automatic step_t lfsr_step(input logic [63:0] state,
                                        input logic [63:0] taps,
                                        input int          width);
        step_t       r;
        logic [63:0] mask;
        mask      = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        r.bit_out = |(state & (64'd1 << (width - 1)));
        r.next    = ((state << 1) | {63'd0, ^(state & taps)}) & mask;
        return r;
    endfunction

endpackage

// File: rtl/lfsr_stream_gen_if.sv
// rtl/lfsr_stream_gen_if.sv - valid/ready word stream between generator and consumer
interface lfsr_stream_gen_if #(
    parameter int OUT_BITS = 8
);
    logic [OUT_BITS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR register with seed load, step and zero-seed guard
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hD008,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'h0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             seed_fixed
);

    step_t            nxt;
    logic [WIDTH-1:0] state_next;
    logic             seed_zero;

    always_comb nxt = lfsr_step(64'(state), 64'(TAPS), WIDTH);

    assign state_next = WIDTH'(nxt.next);
    assign bit_out    = nxt.bit_out;
    assign seed_zero  = (seed == '0);

    // A zero seed would lock the register at zero forever, so it is replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEED_DEFAULT;
            seed_fixed <= 1'b0;
        end else if (load) begin
            state      <= seed_zero ? SEED_DEFAULT : seed;
            seed_fixed <= seed_zero;
        end else begin
            seed_fixed <= 1'b0;
            if (step) begin
                state <= state_next;
            end
        end
    end

endmodule

// File: rtl/lfsr_stream_gen.sv
// rtl/lfsr_stream_gen.sv - packs serial LFSR bits into words on a valid/ready stream
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hD008,
    parameter int               OUT_BITS     = 8,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'h0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed,
    lfsr_stream_gen_if.master    out_if,
    output logic                 seed_fixed,
    output logic [WIDTH-1:0]     lfsr_state
);

    localparam int               CNT_W    = $clog2(OUT_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BITS - 1);

    gen_state_e          fsm;
    logic [CNT_W-1:0]    bit_cnt;
    logic [OUT_BITS-1:0] word;
    logic [OUT_BITS-1:0] word_next;
    logic [OUT_BITS-1:0] out_data_q;
    logic                out_valid_q;
    logic                step;
    logic                emit_bit;

    // The load cycle never steps, so a fresh seed always yields the first bit.
    assign step      = (fsm == FILL) && en && !seed_load;
    assign word_next = OUT_BITS'({word, emit_bit});

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (seed_load),
        .seed       (seed),
        .step       (step),
        .state      (lfsr_state),
        .bit_out    (emit_bit),
        .seed_fixed (seed_fixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            bit_cnt     <= '0;
            word        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (seed_load) begin
            fsm         <= FILL;
            bit_cnt     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                end
                FILL: begin
                    if (en) begin
                        word <= word_next;
                        if (bit_cnt == CNT_LAST) begin
                            out_data_q  <= word_next;
                            out_valid_q <= 1'b1;
                            bit_cnt     <= '0;
                            fsm         <= VALID;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                VALID: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm         <= FILL;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb/tb_lfsr_stream_gen.sv - self-checking bench with a behavioural word-stream model
module tb_lfsr_stream_gen;

    localparam int TAPS_I = 32'h0000_D008;
    localparam int DEF_I  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0;
    logic        seed_fixed;
    logic [15:0] lfsr_state;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_stream_gen_if #(.OUT_BITS(8)) s_if ();

    lfsr_stream_gen #(
        .WIDTH        (16),
        .TAPS         (16'hD008),
        .OUT_BITS     (8),
        .SEED_DEFAULT (16'h0001)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .seed_load  (seed_load),
        .seed       (seed),
        .out_if     (s_if.master),
        .seed_fixed (seed_fixed),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the emitted sequence is the MSB stream of the register,
    // eight bits per word, with the stream stalled while a word awaits acceptance.
    int m_lfsr  = DEF_I;
    int m_word  = 0;
    int m_bits  = 0;
    int m_data  = 0;
    bit m_run   = 1'b0;
    bit m_valid = 1'b0;
    bit m_fixed = 1'b0;

    function automatic int next_lfsr(input int s);
        int fb;
        fb = $countones(s & TAPS_I) % 2;
        return ((s << 1) | fb) & 32'hFFFF;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr = DEF_I; m_word = 0; m_bits = 0; m_data = 0;
            m_run = 1'b0; m_valid = 1'b0; m_fixed = 1'b0;
        end else begin
            m_fixed = 1'b0;
            if (seed_load) begin
                m_lfsr  = (seed == 16'h0) ? DEF_I : int'(seed);
                m_fixed = (seed == 16'h0);
                m_bits  = 0;
                m_valid = 1'b0;
                m_run   = 1'b1;
            end else if (m_valid) begin
                if (s_if.out_ready) m_valid = 1'b0;
            end else if (m_run && en) begin
                m_word = ((m_word * 2) + ((m_lfsr >> 15) & 1)) % 256;
                m_lfsr = next_lfsr(m_lfsr);
                m_bits++;
                if (m_bits == 8) begin
                    m_data  = m_word;
                    m_valid = 1'b1;
                    m_bits  = 0;
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cyc_valid", 32'(s_if.out_valid), 32'(m_valid));
            chk("cyc_data",  32'(s_if.out_data), m_data);
            chk("cyc_lfsr",  32'(lfsr_state), m_lfsr);
            chk("cyc_fixed", 32'(seed_fixed), 32'(m_fixed));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] s);
        seed_load = 1'b1;
        seed      = s;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!s_if.out_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    int n;
    int m;

    initial begin
        s_if.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(s_if.out_valid), 32'h0);
        chk("rst_data",  32'(s_if.out_data), 32'h0);
        chk("rst_lfsr",  32'(lfsr_state), 32'h0001);
        chk("rst_fixed", 32'(seed_fixed), 32'h0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) tick();
        chk("idle_hold", 32'(lfsr_state), 32'h0001);

        // First and second word from seed 1
        s_if.out_ready = 1'b1;
        load(16'h0001);
        wait_valid(n);
        chk("s1_latency", n, 8);
        chk("s1_data", 32'(s_if.out_data), 32'h00);
        chk("s1_lfsr", 32'(lfsr_state), 32'h0111);
        tick();
        wait_valid(m);
        chk("s2_period", m + 1, 9);
        chk("s2_data", 32'(s_if.out_data), 32'h01);
        chk("s2_lfsr", 32'(lfsr_state), 32'h111A);

        // Back-pressure holds word and register
        s_if.out_ready = 1'b0;
        load(16'h0001);
        wait_valid(n);
        chk("s3_latency", n, 8);
        repeat (20) tick();
        chk("s3_hold_valid", 32'(s_if.out_valid), 32'h1);
        chk("s3_hold_data", 32'(s_if.out_data), 32'h00);
        chk("s3_hold_lfsr", 32'(lfsr_state), 32'h0111);
        s_if.out_ready = 1'b1;
        tick();
        wait_valid(m);
        chk("s3_period", m + 1, 9);
        chk("s3_data2", 32'(s_if.out_data), 32'h01);

        // Zero seed is replaced
        load(16'h0000);
        chk("s4_fixed_pulse", 32'(seed_fixed), 32'h1);
        chk("s4_lfsr", 32'(lfsr_state), 32'h0001);
        tick();
        chk("s4_fixed_clear", 32'(seed_fixed), 32'h0);
        wait_valid(n);
        chk("s4_latency", n + 1, 8);
        chk("s4_data", 32'(s_if.out_data), 32'h00);
        chk("s4_lfsr2", 32'(lfsr_state), 32'h0111);

        // Enable stall in mid-fill
        load(16'h0001);
        repeat (4) tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        wait_valid(m);
        chk("s5_latency", m + 7, 11);
        chk("s5_data", 32'(s_if.out_data), 32'h00);

        // Reload in VALID wins over a same-cycle handshake
        s_if.out_ready = 1'b0;
        load(16'hACE1);
        wait_valid(n);
        chk("s6_latency", n, 8);
        s_if.out_ready = 1'b1;
        load(16'h1234);
        chk("s6_valid_drop", 32'(s_if.out_valid), 32'h0);
        chk("s6_lfsr", 32'(lfsr_state), 32'h1234);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(s_if.out_valid), 32'h0);
        chk("s6_rst_lfsr", 32'(lfsr_state), 32'h0001);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the model
        load(16'(($urandom % 65535) + 1));
        for (int i = 0; i < 3000; i++) begin
            en             = ($urandom % 4) != 0;
            s_if.out_ready = ($urandom % 3) != 0;
            seed_load      = ($urandom % 64) == 0;
            seed           = (($urandom % 8) == 0) ? 16'h0 : 16'($urandom);
            tick();
        end
        seed_load = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_gen.md
Name: lfsr_stream_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random generator that packs OUT_BITS serial LFSR output bits into words and presents them on a valid/ready stream. It replaces the fixed 16-bit free-running generator. It adds run-time seeding with zero-seed protection, an enable/stall input, a configurable tap polynomial and back-pressure. It feeds IV/nonce and test-pattern generation in the AES-GCM datapath.

Parameters:
WIDTH, 16, LFSR state width; legal range 4..64.
TAPS, 16'hD008, feedback mask with WIDTH bits; bit k set means state[k] enters the XOR. The default is x^16+x^15+x^13+x^4+1.
OUT_BITS, 8, bits per output word; legal range 1..WIDTH.
SEED_DEFAULT, 16'h0001, non-zero state loaded at reset and substituted for a zero seed.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  step enable; when low, FILL stalls.
seed_load  in  1  single-cycle request to load seed and restart word assembly.
seed  in  WIDTH  seed value, sampled when seed_load=1.
out_data  out  OUT_BITS  assembled random word.
out_valid  out  1  out_data is valid.
out_ready  in  1  consumer accepts the word when out_valid and out_ready are both 1.
seed_fixed  out  1  one-cycle pulse: a zero seed was replaced by SEED_DEFAULT.
lfsr_state  out  WIDTH  current LFSR register, for debug and verification.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, lfsr=SEED_DEFAULT, bit_cnt=0, out_data=0, out_valid=0, seed_fixed=0.
- Step rule: fb = XOR-reduce(lfsr & TAPS); lfsr_next = {lfsr[WIDTH-2:0], fb}. The bit emitted on a step is lfsr[WIDTH-1], taken before the shift.
- Word assembly: word_next = {word[OUT_BITS-2:0], emitted bit}. The first emitted bit ends up as the word MSB.
- State machine:
  - IDLE: lfsr holds, out_valid=0. seed_load moves to FILL.
  - FILL: on each cycle with en=1, perform one step and set bit_cnt+1. On the step with bit_cnt=OUT_BITS-1, the next cycle has state=VALID, out_valid=1, out_data=the completed word, bit_cnt=0. With en=0, nothing changes.
  - VALID: lfsr and out_data hold, independent of en. When out_valid and out_ready are both 1, the next cycle has state=FILL and out_valid=0.
- Latency: the first out_valid rises exactly OUT_BITS cycles after the seed_load cycle, provided en is held high. Sustained throughput is one word per OUT_BITS+1 cycles.
- seed_load (any state, highest priority):
  - lfsr <= seed, or SEED_DEFAULT with seed_fixed=1 for one cycle if seed==0.
  - bit_cnt <= 0, out_valid <= 0, state <= FILL.
  - A word pending in VALID is discarded even if out_ready=1 in the same cycle.
  - No step occurs in the load cycle.
- seed_load together with en=0: the load still happens; FILL then stalls until en=1.
- The all-zero state is unreachable: reset and the load path both guarantee a non-zero lfsr.
- Reset mid-word: the partial word is lost and the block returns to IDLE.
- out_valid is never deasserted without a handshake, except by seed_load or reset.

Decomposition:
- Shared package lfsr_pkg: state enum {IDLE, FILL, VALID}; a function lfsr_step(state, taps) returning the next state and the emitted bit; default maximal tap masks for widths 8, 16, 32 and 64.
- Sub-module lfsr_core: the WIDTH-bit register with the load/step/zero-guard logic. Word packing and the handshake FSM stay in the top level.

Test Plan:
1. Reset then seed_load with seed=0x0001, en=1, out_ready=1 -> out_valid rises 8 cycles after the load; out_data=0x00; lfsr_state=0x0111 at the handshake.
2. Continue from scenario 1 -> second word out_data=0x01; lfsr_state=0x111A after it; out_valid pulses every 9 cycles.
3. Hold out_ready=0 for 20 cycles after the first valid -> out_data stays 0x00, lfsr_state stays 0x0111, out_valid stays 1; release -> the second word is still 0x01.
4. seed_load with seed=0x0000 -> seed_fixed pulses for one cycle; the sequence is identical to scenario 1.
5. Toggle en low for 3 cycles in the middle of FILL -> first valid delayed by exactly 3 cycles; words unchanged.
6. seed_load asserted in VALID with out_ready=1 -> no handshake; out_valid drops; the new sequence starts. Separately, rst_n low mid-FILL -> out_valid=0 immediately and lfsr_state=0x0001.
